unidade_busca: RTL and testbench

- Instruction fetch stage directly upstream of the single-cycle datapath; replaces the direct PC-indexed ROM read.
- Issues word-aligned fetch requests to instruction memory over a valid/ready request channel, accepts in-order responses of variable latency, and buffers them in a small prefetch FIFO.
- Presents {instruction, pc} to the datapath with a valid/ready handshake.
- Flushes and restarts on a redirect (taken branch) from the datapath.

---
 rtl/unidade_busca_pkg.sv | 14 +
 rtl/unidade_busca_if.sv | 33 +++
 rtl/unidade_busca_fila.sv | 64 ++++++
 rtl/unidade_busca.sv | 96 +++++++++
 tb/tb_unidade_busca.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg: shared constants and helpers for the fetch stage.
// Provides XLEN, the NOP encoding, the default reset PC and word alignment.
package unidade_busca_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP          = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// unidade_busca_if: fetch-stage bundle (imem request/response, inst to datapath, redirect).
// master = fetch unit side; slave = memory + datapath side.
interface unidade_busca_if
    import unidade_busca_pkg::*;
();

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/unidade_busca_fila.sv
// fila_busca: synchronous FIFO, DEPTH x W, registered storage, head read from the array.
// Ports: push/din, pop, clear (wins over push/pop), dout (head), full, empty, count.
module fila_busca #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    input  logic                   clear,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A push at full is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push && !clear) mem_q[wr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign count = cnt_q;

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch with credit-limited imem requests and a prefetch FIFO.
// Ports: clk, reset (async, active-low), bus (unidade_busca_if.master).
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    unidade_busca_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic              req_fire, rsp_keep, rsp_drop;
    logic              fifo_empty;
    logic [XLEN-1:0]   tag_pc;
    logic [2*XLEN-1:0] fifo_head;
    logic              tag_full_unused, tag_empty_unused, fifo_full_unused;
    logic [CW-1:0]     tag_count_unused;

    // Discarded requests still hold credit until their response returns.
    assign credit_used        = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign bus.imem_req_valid = reset & ~bus.redirect
                              & (credit_used < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_drop           = bus.imem_rsp_valid & (discard_q != '0);
    assign rsp_keep           = bus.imem_rsp_valid & (discard_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        if (rsp_drop) discard_d  = discard_q - 1'b1;
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        // Every response still owed after this edge belongs to the old path.
        if (bus.redirect) begin
            fetch_pc_d = align_word(bus.redirect_pc);
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fila_busca #(.DEPTH(DEPTH), .W(XLEN)) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .din   (fetch_pc_q),
        .pop   (rsp_keep),
        .clear (bus.redirect),
        .dout  (tag_pc),
        .full  (tag_full_unused),
        .empty (tag_empty_unused),
        .count (tag_count_unused)
    );

    fila_busca #(.DEPTH(DEPTH), .W(2*XLEN)) u_fila (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_keep),
        .din   ({tag_pc, bus.imem_rsp_data}),
        .pop   (bus.inst_valid & bus.inst_ready),
        .clear (bus.redirect),
        .dout  (fifo_head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.inst_valid = ~fifo_empty;
    assign bus.inst       = fifo_head[XLEN-1:0];
    assign bus.inst_pc    = fifo_head[2*XLEN-1:XLEN];

    assert property (@(posedge clk) disable iff (!reset)
        !(bus.imem_rsp_valid && outstanding_q == '0))
    else $error("imem response with nothing outstanding");

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed + random checks of unidade_busca against a queue-based model.
// The model tracks in-order memory traffic with path epochs; stale responses are dropped.
module tb_unidade_busca;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    unidade_busca_if bus ();

    unidade_busca #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_valid = -1;
    int          epoch = 0;
    int          lat_fix = 1;
    logic        rdy_v = 0, ird_v = 0, redir_v = 0;
    logic [31:0] rpc_v = 0;
    logic [31:0] exp_addr = RESET_PC;
    mreq_t       memq[$];
    logic [31:0] fq[$];
    logic [31:0] fired[$];
    logic [31:0] cons[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the negedge, check, advance model, wait next negedge.
    task automatic cycle();
        mreq_t e;
        logic  rsp_v, exp_rv, fire, take;
        bus.imem_req_ready = rdy_v;
        bus.inst_ready     = ird_v;
        bus.redirect       = redir_v;
        bus.redirect_pc    = rpc_v;
        rsp_v = (memq.size() > 0) && (memq[0].due <= cyc);
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_v ? word_of(memq[0].addr) : 32'h0;
        #1;
        exp_rv = !redir_v && (fq.size() + memq.size() < DEPTH);
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, exp_addr);
        chk("inst_valid", bus.inst_valid, fq.size() > 0);
        if (fq.size() > 0) begin
            chk("inst_pc", bus.inst_pc, fq[0]);
            chk("inst", bus.inst, word_of(fq[0]));
        end
        if (bus.inst_valid && first_valid < 0) first_valid = cyc;
        fire = exp_rv && rdy_v;
        take = (fq.size() > 0) && ird_v;
        if (take) cons.push_back(fq[0]);
        if (rsp_v) e = memq.pop_front();
        if (redir_v) begin
            epoch++;
            fq.delete();
            exp_addr = rpc_v & ~32'h3;
        end else begin
            if (take) void'(fq.pop_front());
            if (rsp_v && e.epoch == epoch) fq.push_back(e.addr);
            if (fire) begin
                memq.push_back('{addr: exp_addr,
                                 due: cyc + (lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4))),
                                 epoch: epoch});
                fired.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = 0;
        bus.inst_ready     = 0;
        bus.redirect       = 0;
        bus.redirect_pc    = 0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        memq.delete();
        fq.delete();
        fired.delete();
        cons.delete();
        exp_addr    = RESET_PC;
        epoch++;
        cyc         = 0;
        first_valid = -1;
        redir_v     = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        @(negedge clk);

        // Streaming, latency 1, always ready.
        do_reset();
        lat_fix = 1; rdy_v = 1; ird_v = 1;
        repeat (20) cycle();
        chk("a_first_valid_cyc", first_valid, 2);
        chk("a_req0", fired[0], 32'h0);
        chk("a_req1", fired[1], 32'h4);
        chk("a_req2", fired[2], 32'h8);
        chk("a_consumed", cons.size(), 18);

        // Datapath stalled: credit stops at DEPTH requests.
        do_reset();
        lat_fix = 1; rdy_v = 1; ird_v = 0;
        repeat (10) cycle();
        chk("b_fired", fired.size(), 4);
        chk("b_last_req", fired[3], 32'hC);
        chk("b_req_stall", bus.imem_req_valid, 0);
        chk("b_full_valid", bus.inst_valid, 1);
        fired.delete();
        ird_v = 1;
        repeat (10) cycle();
        chk("b_drain0", cons[0], 32'h0);
        chk("b_drain1", cons[1], 32'h4);
        chk("b_drain2", cons[2], 32'h8);
        chk("b_drain3", cons[3], 32'hC);
        chk("b_resume", fired[0], 32'h10);

        // Redirect with two requests in flight at latency 3.
        do_reset();
        lat_fix = 3; rdy_v = 1; ird_v = 1;
        repeat (2) cycle();
        fired.delete();
        redir_v = 1; rpc_v = 32'h103;
        cycle();
        redir_v = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (bus.inst_valid) got = 1;
        end
        chk("c_got_valid", got, 1);
        chk("c_first_pc", bus.inst_pc, 32'h100);
        chk("c_first_req", fired[0], 32'h100);

        // Redirect coinciding with a consume and a response.
        do_reset();
        lat_fix = 1; rdy_v = 1; ird_v = 1;
        repeat (6) cycle();
        redir_v = 1; rpc_v = 32'h200;
        cycle();
        redir_v = 0;
        chk("d_no_valid", bus.inst_valid, 0);
        repeat (6) cycle();

        // Address wrap at the top of memory.
        fired.delete();
        redir_v = 1; rpc_v = 32'hFFFF_FFF8;
        cycle();
        redir_v = 0;
        repeat (8) cycle();
        chk("e_req0", fired[0], 32'hFFFF_FFF8);
        chk("e_req1", fired[1], 32'hFFFF_FFFC);
        chk("e_req2", fired[2], 32'h0000_0000);

        // Randomized traffic.
        lat_fix = 0;
        for (int i = 0; i < 1500; i++) begin
            rdy_v   = ($urandom_range(0, 3) != 0);
            ird_v   = ($urandom_range(0, 3) != 0);
            redir_v = ($urandom_range(0, 15) == 0);
            rpc_v   = $urandom;
            cycle();
        end
        redir_v = 0;

        // Reset mid-stream: two in flight, FIFO half full.
        do_reset();
        lat_fix = 3; rdy_v = 1; ird_v = 0;
        repeat (5) cycle();
        chk("f_pre_valid", bus.inst_valid, 1);
        do_reset();
        lat_fix = 1; rdy_v = 1; ird_v = 1;
        repeat (6) cycle();
        chk("f_first_req", fired[0], RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
